// File: rtl/alu_sequencer.sv
// alu_sequencer: drives a shared 8-bit ALU through two byte-wide cycles
// (low byte, then high byte) to perform 16-bit add, subtract, increment
// and 6502-style indexed address generation. Indexed adds with no low-byte
// carry skip the high-byte cycle and reuse the base high byte directly.
module alu_sequencer #(
  parameter int                  OP_WIDTH = 3,
  parameter logic [OP_WIDTH-1:0] OP_ADD   = 3'd0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          cmd,
  input  logic [15:0]         op_a,
  input  logic [15:0]         op_b,
  output logic                busy,
  output logic                done,
  output logic [15:0]         result,
  output logic                carry,
  output logic                overflow,
  output logic                zero,
  output logic                negative,
  output logic                page_cross,
  output logic [7:0]          alu_input_a,
  output logic [7:0]          alu_input_b,
  output logic                alu_carry_in,
  output logic                alu_invert_b,
  output logic [OP_WIDTH-1:0] alu_operation,
  input  logic [7:0]          alu_out,
  input  logic                alu_carry_out,
  input  logic                alu_overflow_out
);

  localparam logic [1:0] CMD_ADD16 = 2'b00;
  localparam logic [1:0] CMD_SUB16 = 2'b01;
  localparam logic [1:0] CMD_INC16 = 2'b10;
  localparam logic [1:0] CMD_IDX   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  cmd_r;
  logic [15:0] a_r;
  logic [15:0] b_r;
  logic        lo_c;

  // ALU operand steering: low bytes in LO, high bytes plus chained carry in HI,
  // and a quiet all-zero add while idle.
  always_comb begin
    alu_input_a   = 8'h00;
    alu_input_b   = 8'h00;
    alu_carry_in  = 1'b0;
    alu_invert_b  = 1'b0;
    alu_operation = OP_ADD;
    case (state)
      LO: begin
        alu_input_a  = a_r[7:0];
        alu_input_b  = (cmd_r == CMD_INC16) ? 8'h00 : b_r[7:0];
        alu_invert_b = (cmd_r == CMD_SUB16);
        alu_carry_in = (cmd_r == CMD_SUB16) || (cmd_r == CMD_INC16);
      end
      HI: begin
        alu_input_a  = a_r[15:8];
        alu_input_b  = ((cmd_r == CMD_INC16) || (cmd_r == CMD_IDX)) ? 8'h00 : b_r[15:8];
        alu_invert_b = (cmd_r == CMD_SUB16);
        alu_carry_in = lo_c;
      end
      default: begin
        alu_input_a   = 8'h00;
        alu_input_b   = 8'h00;
        alu_carry_in  = 1'b0;
        alu_invert_b  = 1'b0;
        alu_operation = OP_ADD;
      end
    endcase
  end

  // Sequencer FSM: latches the command on start, captures each ALU byte and
  // produces the registered result, flags and single-cycle done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cmd_r      <= CMD_ADD16;
      a_r        <= 16'h0000;
      b_r        <= 16'h0000;
      lo_c       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= 16'h0000;
      carry      <= 1'b0;
      overflow   <= 1'b0;
      zero       <= 1'b0;
      negative   <= 1'b0;
      page_cross <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cmd_r <= cmd;
            a_r   <= op_a;
            b_r   <= op_b;
            busy  <= 1'b1;
            state <= LO;
          end
        end
        LO: begin
          result[7:0] <= alu_out;
          lo_c        <= alu_carry_out;
          if ((cmd_r == CMD_IDX) && !alu_carry_out) begin
            result[15:8] <= a_r[15:8];
            carry        <= 1'b0;
            overflow     <= 1'b0;
            page_cross   <= 1'b0;
            zero         <= ({a_r[15:8], alu_out} == 16'h0000);
            negative     <= a_r[15];
            busy         <= 1'b0;
            done         <= 1'b1;
            state        <= IDLE;
          end else begin
            state <= HI;
          end
        end
        HI: begin
          result[15:8] <= alu_out;
          carry        <= alu_carry_out;
          overflow     <= alu_overflow_out;
          page_cross   <= lo_c;
          zero         <= ({alu_out, result[7:0]} == 16'h0000);
          negative     <= alu_out[7];
          busy         <= 1'b0;
          done         <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vectors for alu_sequencer with an 8-bit ALU model.
// Expected responses are queued when a start is issued and popped by a
// monitor whenever done is seen, including the cycle the result arrived.
module tb_alu_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  cmd;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        carry;
  logic        overflow;
  logic        zero;
  logic        negative;
  logic        page_cross;
  logic [7:0]  alu_input_a;
  logic [7:0]  alu_input_b;
  logic        alu_carry_in;
  logic        alu_invert_b;
  logic [2:0]  alu_operation;
  logic [7:0]  alu_out;
  logic        alu_carry_out;
  logic        alu_overflow_out;

  typedef struct {
    string       name;
    logic [15:0] res;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
    logic        pc;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  alu_sequencer #(.OP_WIDTH(3), .OP_ADD(3'd0)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .cmd              (cmd),
    .op_a             (op_a),
    .op_b             (op_b),
    .busy             (busy),
    .done             (done),
    .result           (result),
    .carry            (carry),
    .overflow         (overflow),
    .zero             (zero),
    .negative         (negative),
    .page_cross       (page_cross),
    .alu_input_a      (alu_input_a),
    .alu_input_b      (alu_input_b),
    .alu_carry_in     (alu_carry_in),
    .alu_invert_b     (alu_invert_b),
    .alu_operation    (alu_operation),
    .alu_out          (alu_out),
    .alu_carry_out    (alu_carry_out),
    .alu_overflow_out (alu_overflow_out)
  );

  // Behavioural 8-bit ALU: add with optional B inversion and carry-in
  logic [7:0] alu_b_eff;
  logic [8:0] alu_sum;
  assign alu_b_eff        = alu_invert_b ? ~alu_input_b : alu_input_b;
  assign alu_sum          = {1'b0, alu_input_a} + {1'b0, alu_b_eff} + {8'h00, alu_carry_in};
  assign alu_out          = alu_sum[7:0];
  assign alu_carry_out    = alu_sum[8];
  assign alu_overflow_out = (alu_input_a[7] == alu_b_eff[7]) && (alu_sum[7] != alu_input_a[7]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to time-stamp accepts and done pulses
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issues one command at a negedge, queues its expectation, and returns at
  // the negedge of the done cycle so the next call is back-to-back.
  task automatic applyStimulus(input string name, input logic [1:0] c, input logic [15:0] a,
                               input logic [15:0] b, input logic [15:0] res, input logic ec,
                               input logic ev, input logic ez, input logic en, input logic epc,
                               input int lat);
    exp_t e;
    start = 1'b1;
    cmd   = c;
    op_a  = a;
    op_b  = b;
    e.name = name; e.res = res; e.c = ec; e.v = ev; e.z = ez; e.n = en; e.pc = epc;
    e.due  = cyc + 1 + lat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    op_a  = 16'hDEAD;
    op_b  = 16'hBEEF;
    repeat (lat) @(negedge clk);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 16'(done), 16'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput({e.name, "_result"},     result,             e.res);
        checkOutput({e.name, "_carry"},      16'(carry),         16'(e.c));
        checkOutput({e.name, "_overflow"},   16'(overflow),      16'(e.v));
        checkOutput({e.name, "_zero"},       16'(zero),          16'(e.z));
        checkOutput({e.name, "_negative"},   16'(negative),      16'(e.n));
        checkOutput({e.name, "_page_cross"}, 16'(page_cross),    16'(e.pc));
        checkOutput({e.name, "_latency"},    16'(cyc),           16'(e.due));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    cmd   = 2'b00;
    op_a  = 16'h0000;
    op_b  = 16'h0000;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy",   16'(busy),   16'd0);
    checkOutput("reset_done",   16'(done),   16'd0);
    checkOutput("reset_result", result,      16'h0000);
    checkOutput("reset_flags",  16'({carry, overflow, zero, negative, page_cross}), 16'd0);
    checkOutput("idle_alu_a",   16'(alu_input_a), 16'd0);
    checkOutput("idle_alu_cin", 16'({alu_carry_in, alu_invert_b}), 16'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] directed vectors");
    applyStimulus("add_12ff", 2'b00, 16'h12FF, 16'h0001, 16'h1300, 0, 0, 0, 0, 1, 2);
    applyStimulus("add_7fff", 2'b00, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0, 1, 1, 2);
    applyStimulus("add_ffff", 2'b00, 16'hFFFF, 16'h0002, 16'h0001, 1, 0, 0, 0, 1, 2);
    applyStimulus("sub_1000", 2'b01, 16'h1000, 16'h0001, 16'h0FFF, 1, 0, 0, 0, 0, 2);
    applyStimulus("sub_0000", 2'b01, 16'h0000, 16'h0001, 16'hFFFF, 0, 0, 0, 1, 0, 2);
    applyStimulus("sub_8000", 2'b01, 16'h8000, 16'h0001, 16'h7FFF, 1, 1, 0, 0, 0, 2);
    applyStimulus("inc_00fe", 2'b10, 16'h00FE, 16'h1234, 16'h00FF, 0, 0, 0, 0, 0, 2);
    applyStimulus("idx_nopc", 2'b11, 16'h20F0, 16'hAB05, 16'h20F5, 0, 0, 0, 0, 0, 1);
    applyStimulus("idx_pc",   2'b11, 16'h20F0, 16'hFF20, 16'h2110, 0, 0, 0, 0, 1, 2);
    applyStimulus("idx_nopc2",2'b11, 16'h8001, 16'h0001, 16'h8002, 0, 0, 0, 1, 0, 1);

    $display("[TB] start held high, operands changed while busy");
    begin
      exp_t e;
      start = 1'b1;
      cmd   = 2'b00;
      op_a  = 16'h0100;
      op_b  = 16'h0001;
      e.name = "held_1"; e.res = 16'h0101; e.c = 0; e.v = 0; e.z = 0; e.n = 0; e.pc = 0;
      e.due  = cyc + 3;
      sb.push_back(e);
      @(negedge clk);
      op_a = 16'hAAAA;
      @(negedge clk);
      op_a = 16'h0200;
      @(negedge clk);
      op_a = 16'h0300;
      e.name = "held_2"; e.res = 16'h0301;
      e.due  = cyc + 3;
      sb.push_back(e);
      @(negedge clk);
      op_a = 16'h5555;
      op_b = 16'h7777;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
    end

    $display("[TB] wrap-around increment then reset during HI");
    applyStimulus("inc_ffff", 2'b10, 16'hFFFF, 16'h0000, 16'h0000, 1, 0, 1, 0, 1, 2);
    start = 1'b1;
    cmd   = 2'b00;
    op_a  = 16'h1234;
    op_b  = 16'h1111;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_busy",   16'(busy),   16'd0);
    checkOutput("abort_done",   16'(done),   16'd0);
    checkOutput("abort_result", result,      16'h0000);
    checkOutput("abort_flags",  16'({carry, overflow, zero, negative, page_cross}), 16'd0);
    repeat (6) @(negedge clk);

    checkOutput("alu_operation", 16'(alu_operation), 16'd0);
    checkOutput("scoreboard_drained", 16'(sb.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller that drives the 8-bit `alu` to perform 16-bit operations: 16-bit add, subtract and increment, plus 6502-style indexed address generation (base + 8-bit index). It runs one byte per cycle, low byte first, chaining the carry through a register. For index adds with no low-byte carry, it skips the high-byte cycle. It sits between the CPU control unit, via a start/busy/done handshake, and the shared `alu` datapath instance.

## Interface
- `OP_WIDTH`, default 3: width of the ALU `operation` code.
- `OP_ADD`, default 3'd0: `operation` code that selects ALU addition.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted only in IDLE.
- `cmd`  in  2  operation code:
  - 00 ADD16 (a+b)
  - 01 SUB16 (a-b)
  - 10 INC16 (a+1)
  - 11 IDX (a + {8'h00, b[7:0]})
- `op_a`  in  16  operand A / base address.
- `op_b`  in  16  operand B / index (IDX uses b[7:0] only).
- `busy`  out  1  high while an operation is in progress (LO or HI state).
- `done`  out  1  one-cycle pulse; result and flags are valid in that cycle.
- `result`  out  16  registered result; held until the next accepted start.
- `carry`  out  1  carry out of the final ALU cycle; for SUB16, 1 means no borrow.
- `overflow`  out  1  signed overflow from the high-byte cycle.
- `zero`  out  1  result == 16'h0000.
- `negative`  out  1  result[15].
- `page_cross`  out  1  carry out of the low-byte cycle.
- `alu_input_a`, `alu_input_b`  out  8 each  ALU operands.
- `alu_carry_in`, `alu_invert_b`  out  1 each  ALU carry-in and operand-B inversion.
- `alu_operation`  out  OP_WIDTH  ALU operation code; always OP_ADD.
- `alu_out`  in  8  combinational ALU result.
- `alu_carry_out`, `alu_overflow_out`  in  1 each  combinational ALU flags.

## Operation
- FSM states:
  - IDLE: if `start`, latch `cmd`, `op_a`, `op_b`, then go to LO.
  - LO: drive the low bytes. Capture `alu_out` into result[7:0] and `alu_carry_out` into `lo_c`. Go to HI, except IDX with the ALU carry 0, which goes to IDLE.
  - HI: drive the high bytes with `alu_carry_in` = `lo_c`. Capture result[15:8], carry and overflow. Go to IDLE.
- Operand drive per command:
  - ADD16: B = b byte, invert_b = 0, LO carry_in = 0.
  - SUB16: B = b byte, invert_b = 1, LO carry_in = 1.
  - INC16: B = 8'h00, invert_b = 0, LO carry_in = 1.
  - IDX: LO B = b[7:0], HI B = 8'h00, invert_b = 0, LO carry_in = 0.
- IDX skip path (no low carry): result[15:8] = a[15:8]; carry = 0, overflow = 0, page_cross = 0.
- ALU drive in IDLE: A = B = 0, carry_in = 0, invert_b = 0, operation = OP_ADD.
- Flags:
  - `zero` and `negative` are derived from the final registered result.
  - `page_cross` = `lo_c` for all commands.
  - All flags update on the same edge as the final result byte.
- `start` while `busy` is ignored, not queued. Input operand changes after acceptance have no effect.
- Reset, in any state including mid-operation:
  - next state IDLE
  - `busy` = 0, `done` = 0
  - `result` = 0, all flags = 0, `lo_c` = 0
  - an aborted operation never produces `done`.

## Timing
- Start is sampled at edge N.
- Two-cycle ops (all except IDX without page cross):
  - `busy` is high in cycles N..N+1 (LO, HI).
  - `done` is high for the one cycle after edge N+2; results update at edge N+2.
- IDX without page cross: `busy` is high in cycle N only; `done` is high after edge N+1.
- `done` coincides with IDLE, so a `start` at the edge ending the `done` cycle is accepted. Sustained throughput is one op per 3 cycles (2 for non-crossing IDX).
- `done` is a registered, single-cycle pulse, even if `start` is held high continuously.
- The ALU is combinational: its outputs are sampled at the end of the cycle in which the sequencer drives it.

## Test plan
- ADD16: 0x12FF + 0x0001 -> result 0x1300, carry 0, page_cross 1, overflow 0; `done` 3 edges after accept. ADD16: 0x7FFF + 0x0001 -> result 0x8000, overflow 1, negative 1.
- SUB16: 0x1000 - 0x0001 -> result 0x0FFF, carry 1. SUB16: 0x0000 - 0x0001 -> result 0xFFFF, carry 0, negative 1.
- INC16: 0xFFFF -> result 0x0000, carry 1, zero 1, page_cross 1. INC16: 0x00FE -> result 0x00FF, carry 0, page_cross 0.
- IDX: 0x20F0 + b 0x05 -> result 0x20F5, page_cross 0, `done` 2 edges after accept. IDX: 0x20F0 + b 0x20 -> result 0x2110, page_cross 1, `done` 3 edges after accept.
- Handshake:
  - hold `start` high continuously and change `op_a` during `busy` -> exactly one `done` per accepted op, results use the latched operands.
  - back-to-back: a second start accepted in the `done` cycle produces `done` 3 cycles later.
- Reset: assert `reset` for one cycle while in HI -> next cycle `busy` 0, `done` 0, result 0x0000, all flags 0, and no later `done` pulse.
